// File: rtl/tetris_video_pkg.sv
// rtl/tetris_video_pkg.sv - shared types, geometry defaults and palette for the Tetris pixel renderer
package tetris_video_pkg;

    localparam int H_ACTIVE_DEF  = 640;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int CELL_LOG2_DEF = 4;
    localparam int BOARD_X0_DEF  = 240;
    localparam int BOARD_Y0_DEF  = 80;
    localparam int COLS_DEF      = 10;
    localparam int ROWS_DEF      = 20;
    localparam int BORDER_DEF    = 4;

    typedef enum logic [1:0] {
        REGION_BG     = 2'd0,
        REGION_BORDER = 2'd1,
        REGION_BOARD  = 2'd2
    } region_e;

    localparam logic [23:0] RGB_BLACK  = 24'h000000;
    localparam logic [23:0] RGB_BORDER = 24'h808080;

    // Index 0 is the empty cell and renders as background black.
    function automatic logic [23:0] palette_rgb(input logic [2:0] idx);
        case (idx)
            3'd1:    return 24'h00FFFF;
            3'd2:    return 24'hFFFF00;
            3'd3:    return 24'h8000FF;
            3'd4:    return 24'h00FF00;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            3'd7:    return 24'hFF8000;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/tetris_pixel_renderer_if.sv
// rtl/tetris_pixel_renderer_if.sv - board cell write port bundle
// master: game-logic side driving writes; slave: board storage consuming them.
interface tetris_pixel_renderer_if;
    logic       wr_en;
    logic [3:0] wr_col;
    logic [4:0] wr_row;
    logic [2:0] wr_color;

    modport master (output wr_en, wr_col, wr_row, wr_color);
    modport slave  (input  wr_en, wr_col, wr_row, wr_color);
endinterface

// File: rtl/tetris_board_ram.sv
// rtl/tetris_board_ram.sv - COLS x ROWS board of 3-bit colour indices
// Ports: pixclk/reset_n (sync clear of all cells), wr (write port),
//        i_rd_col/i_rd_row (read address), o_rd_data (registered read data).
module tetris_board_ram
    import tetris_video_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic                    pixclk,
    input  logic                    reset_n,
    tetris_pixel_renderer_if.slave  wr,
    input  logic [3:0]              i_rd_col,
    input  logic [4:0]              i_rd_row,
    output logic [2:0]              o_rd_data
);

    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);

    // Flat vector so the whole board clears with a single assignment.
    logic [3*DEPTH-1:0] r_mem;
    logic [2:0]         r_rd_data;
    logic [AW-1:0]      w_wr_idx;
    logic [AW-1:0]      w_rd_idx;
    logic               w_wr_ok;
    logic               w_rd_ok;

    assign w_wr_ok  = wr.wr_en && (int'(wr.wr_col) < COLS) && (int'(wr.wr_row) < ROWS);
    assign w_rd_ok  = (int'(i_rd_col) < COLS) && (int'(i_rd_row) < ROWS);
    assign w_wr_idx = AW'(int'(wr.wr_row) * COLS + int'(wr.wr_col));
    assign w_rd_idx = AW'(int'(i_rd_row) * COLS + int'(i_rd_col));

    // Read samples r_mem before this edge's write lands, so a same-cycle
    // write to the read cell returns the old colour.
    always_ff @(posedge pixclk) begin
        if (!reset_n) begin
            r_mem     <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr_ok) r_mem[3*w_wr_idx +: 3] <= wr.wr_color;
            r_rd_data <= w_rd_ok ? r_mem[3*w_rd_idx +: 3] : 3'd0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tetris_pixel_renderer.sv
// rtl/tetris_pixel_renderer.sv - active-area pixel source drawing a Tetris board ahead of TMDS encoding
// Ports: pixclk/reset_n; VDE_in/CD_in timing inputs; wr_* board write port;
//        R/G/B_data, VDE_out, CD_out (2-cycle aligned); frame_start pulse.
module tetris_pixel_renderer
    import tetris_video_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int CELL_LOG2 = CELL_LOG2_DEF,
    parameter int BOARD_X0  = BOARD_X0_DEF,
    parameter int BOARD_Y0  = BOARD_Y0_DEF,
    parameter int COLS      = COLS_DEF,
    parameter int ROWS      = ROWS_DEF,
    parameter int BORDER    = BORDER_DEF
) (
    input  logic       pixclk,
    input  logic       reset_n,
    input  logic       VDE_in,
    input  logic [1:0] CD_in,
    input  logic       wr_en,
    input  logic [3:0] wr_col,
    input  logic [4:0] wr_row,
    input  logic [2:0] wr_color,
    output logic [7:0] R_data,
    output logic [7:0] G_data,
    output logic [7:0] B_data,
    output logic       VDE_out,
    output logic [1:0] CD_out,
    output logic       frame_start
);

    localparam int CELL = 1 << CELL_LOG2;
    localparam int BX1  = BOARD_X0 + COLS * CELL;
    localparam int BY1  = BOARD_Y0 + ROWS * CELL;

    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_vde_prev;
    logic        r_vs_prev;
    logic        r_frame_start;
    logic        w_vs_rise;
    logic        w_vde_fall;

    region_e     w_region;
    region_e     r_s1_region;
    logic        r_s1_vde;
    logic [1:0]  r_s1_cd;
    logic [3:0]  w_col;
    logic [4:0]  w_row;
    logic [2:0]  w_rd_data;
    int          w_x_int;
    int          w_y_int;

    logic [23:0] w_s1_rgb;
    logic [23:0] r_rgb;
    logic        r_vde_out;
    logic [1:0]  r_cd_out;

    tetris_pixel_renderer_if u_wr_if ();

    assign u_wr_if.wr_en    = wr_en;
    assign u_wr_if.wr_col   = wr_col;
    assign u_wr_if.wr_row   = wr_row;
    assign u_wr_if.wr_color = wr_color;

    assign w_vs_rise  = CD_in[1] & ~r_vs_prev;
    assign w_vde_fall = r_vde_prev & ~VDE_in;

    // vsync takes priority over an end-of-line in the same cycle.
    always_ff @(posedge pixclk) begin
        if (!reset_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_vde_prev    <= 1'b0;
            r_vs_prev     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_vde_prev    <= VDE_in;
            r_vs_prev     <= CD_in[1];
            r_frame_start <= w_vs_rise;
            if (w_vs_rise) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_vde_fall) begin
                r_x <= '0;
                if (r_y != 11'h7FF) r_y <= r_y + 11'd1;
            end else if (VDE_in && (int'(r_x) < H_ACTIVE)) begin
                r_x <= r_x + 11'd1;
            end
        end
    end

    always_comb begin
        w_x_int  = int'(r_x);
        w_y_int  = int'(r_y);
        w_region = REGION_BG;
        if ((w_x_int < H_ACTIVE) && (w_y_int < V_ACTIVE)) begin
            if ((w_x_int >= BOARD_X0) && (w_x_int < BX1) &&
                (w_y_int >= BOARD_Y0) && (w_y_int < BY1)) begin
                w_region = REGION_BOARD;
            end else if ((w_x_int >= BOARD_X0 - BORDER) && (w_x_int < BX1 + BORDER) &&
                         (w_y_int >= BOARD_Y0 - BORDER) && (w_y_int < BY1 + BORDER)) begin
                w_region = REGION_BORDER;
            end
        end
    end

    // Address is only meaningful inside the board; outside it the region
    // tag discards whatever the RAM returns.
    assign w_col = 4'((r_x - 11'(BOARD_X0)) >> CELL_LOG2);
    assign w_row = 5'((r_y - 11'(BOARD_Y0)) >> CELL_LOG2);

    tetris_board_ram #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_board (
        .pixclk    (pixclk),
        .reset_n   (reset_n),
        .wr        (u_wr_if),
        .i_rd_col  (w_col),
        .i_rd_row  (w_row),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge pixclk) begin
        if (!reset_n) begin
            r_s1_region <= REGION_BG;
            r_s1_vde    <= 1'b0;
            r_s1_cd     <= 2'b00;
        end else begin
            r_s1_region <= w_region;
            r_s1_vde    <= VDE_in;
            r_s1_cd     <= CD_in;
        end
    end

    always_comb begin
        w_s1_rgb = RGB_BLACK;
        if (r_s1_vde) begin
            case (r_s1_region)
                REGION_BOARD:  w_s1_rgb = palette_rgb(w_rd_data);
                REGION_BORDER: w_s1_rgb = RGB_BORDER;
                default:       w_s1_rgb = RGB_BLACK;
            endcase
        end
    end

    always_ff @(posedge pixclk) begin
        if (!reset_n) begin
            r_rgb     <= '0;
            r_vde_out <= 1'b0;
            r_cd_out  <= 2'b00;
        end else begin
            r_rgb     <= w_s1_rgb;
            r_vde_out <= r_s1_vde;
            r_cd_out  <= r_s1_cd;
        end
    end

    assign R_data      = r_rgb[23:16];
    assign G_data      = r_rgb[15:8];
    assign B_data      = r_rgb[7:0];
    assign VDE_out     = r_vde_out;
    assign CD_out      = r_cd_out;
    assign frame_start = r_frame_start;

endmodule
